// File: rtl/gcd_lcm_post_if.sv
// Bundle between the gcd front end and the lcm post-processor.
// The master side owns the operand/gcd inputs; the slave side drives the results.
interface gcd_lcm_post_if #(
   parameter int WIDTH = 8
);
   logic               load;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic [WIDTH-1:0]   gcd_y;
   logic               gcd_done;
   logic [2*WIDTH-1:0] lcm;
   logic               valid;
   logic               busy;
   logic               err;

   modport master (
      output load, a, b, gcd_y, gcd_done,
      input  lcm, valid, busy, err
   );

   modport slave (
      input  load, a, b, gcd_y, gcd_done,
      output lcm, valid, busy, err
   );
endinterface

// File: rtl/gcd_lcm_post.sv
// lcm(a,b) = (a / gcd) * b using a serial restoring divider
// followed by a serial shift-add multiplier.
module gcd_lcm_post #(
   parameter int WIDTH = 8
) (
   input logic          clk,
   input logic          rst_n,
   gcd_lcm_post_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_GCD,
      DIV,
      MUL,
      DONE
   } state_t;

   state_t state, state_nx;

   logic [WIDTH-1:0]   ra;
   logic [WIDTH-1:0]   rg;
   logic [WIDTH-1:0]   q;
   logic [WIDTH-1:0]   rem;
   logic [2*WIDTH-1:0] rb_sh;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] lcm_q;
   logic [CW-1:0]      cnt;
   logic               valid_q;
   logic               err_q;

   logic [WIDTH:0]     trial;
   logic               take;
   logic               last;

   // Remainder stays below rg, so the low WIDTH bits hold it exactly.
   assign trial = {rem, ra[WIDTH-1]};
   assign take  = (trial >= {1'b0, rg});
   assign last  = (cnt == '0);

   assign bus.lcm   = lcm_q;
   assign bus.valid = valid_q;
   assign bus.err   = err_q;
   assign bus.busy  = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      if (bus.load) begin
         state_nx = WAIT_GCD;
      end else begin
         unique case (state)
            IDLE:     state_nx = IDLE;
            WAIT_GCD: begin
               if (bus.gcd_done) begin
                  state_nx = (bus.gcd_y == '0) ? IDLE : DIV;
               end
            end
            DIV:      if (last) state_nx = MUL;
            MUL:      if (last) state_nx = DONE;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ra      <= '0;
         rg      <= '0;
         q       <= '0;
         rem     <= '0;
         rb_sh   <= '0;
         acc     <= '0;
         lcm_q   <= '0;
         cnt     <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (bus.load) begin
            ra    <= bus.a;
            rb_sh <= {{WIDTH{1'b0}}, bus.b};
            q     <= '0;
            acc   <= '0;
            rem   <= '0;
         end else begin
            unique case (state)
               WAIT_GCD: begin
                  if (bus.gcd_done) begin
                     rg  <= bus.gcd_y;
                     rem <= '0;
                     cnt <= CW'(WIDTH - 1);
                     if (bus.gcd_y == '0) begin
                        lcm_q   <= '0;
                        err_q   <= 1'b1;
                        valid_q <= 1'b1;
                     end
                  end
               end
               DIV: begin
                  rem <= take ? (trial[WIDTH-1:0] - rg)
                              : trial[WIDTH-1:0];
                  ra  <= {ra[WIDTH-2:0], 1'b0};
                  q   <= {q[WIDTH-2:0], take};
                  cnt <= last ? CW'(WIDTH - 1) : (cnt - CW'(1));
               end
               MUL: begin
                  if (q[0]) acc <= acc + rb_sh;
                  rb_sh <= {rb_sh[2*WIDTH-2:0], 1'b0};
                  q     <= {1'b0, q[WIDTH-1:1]};
                  cnt   <= cnt - CW'(1);
               end
               DONE: begin
                  lcm_q   <= acc;
                  err_q   <= 1'b0;
                  valid_q <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end
endmodule
